uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart of the receive-path baud timing in the UART example set. Accepts one byte per valid/ready handshake and serializes it on `TX` as start bit, 8 data bits LSB-first, optional parity bit, and stop bit. Each bit lasts exactly `CLKS_PER_BIT` clocks. Bit timing comes from an internal baud counter, so no external tick is needed.

---
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_tx.sv | 91 +++++++++
 tb/tb_uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a producer (master) and uart_tx (slave).
interface uart_tx_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;
    modport master (output DATA, VALID, input READY);
    modport slave  (input DATA, VALID, output READY);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with internal baud counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop (8E1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 25
) (
    input  logic     CLKIN,
    input  logic     RESETN,
    uart_tx_if.slave bus,
    output logic     TX,
    output logic     BUSY
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t          state, state_n;
    logic [7:0]      shreg, shreg_n;
    logic [2:0]      bitidx, bitidx_n;
    logic [BW-1:0]   baudcnt, baudcnt_n;
    logic            ready, accept, done;
    assign ready     = (state == IDLE) && RESETN;
    assign accept    = bus.VALID && ready;
    assign done      = (state != IDLE) && (baudcnt == LAST);
    assign bus.READY = ready;
    always_ff @(posedge CLKIN) begin
        if (!RESETN) state <= IDLE;
        else         state <= state_n;
    end
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitidx_n  = bitidx;
        baudcnt_n = (state == IDLE || done) ? '0 : baudcnt + 1'b1;
        case (state)
            IDLE: if (accept) begin
                state_n  = START;
                shreg_n  = bus.DATA;
                bitidx_n = '0;
            end
            START: if (done) state_n = DATA;
            DATA: if (done) begin
                shreg_n  = shreg >> 1;
                bitidx_n = bitidx + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bitidx == 3'd7) state_n = PARITY;
`else
                if (bitidx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (done) state_n = STOP;
`endif
            STOP: if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge CLKIN) begin
        if (!RESETN)     par <= 1'b0;
        else if (accept) par <= ^bus.DATA;
    end
`endif
    // TX and BUSY follow the registered state, so the line moves one clock after each state change
    always_ff @(posedge CLKIN) begin
        if (!RESETN) begin
            shreg   <= '0;
            bitidx  <= '0;
            baudcnt <= '0;
            TX      <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            shreg   <= shreg_n;
            bitidx  <= bitidx_n;
            baudcnt <= baudcnt_n;
            BUSY    <= state != IDLE;
`ifdef UART_TX_PARITY_EN
            TX      <= (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : (state == PARITY) ? par : 1'b1;
`else
            TX      <= (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx at CLKS_PER_BIT=4 and the default 25 against a per-clock frame model.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       v4 = 1'b0, v25 = 1'b0, sel25 = 1'b0;
    logic       tx4, busy4, tx25, busy25;
    logic       tx_o, busy_o, ready_o;
    int         errors = 0, checks = 0;
    uart_tx_if b4 ();
    uart_tx_if b25 ();
    assign b4.DATA   = dat;
    assign b4.VALID  = v4;
    assign b25.DATA  = dat;
    assign b25.VALID = v25;
    assign tx_o    = sel25 ? tx25 : tx4;
    assign busy_o  = sel25 ? busy25 : busy4;
    assign ready_o = sel25 ? b25.READY : b4.READY;
    uart_tx #(.CLKS_PER_BIT(4)) dut4 (.CLKIN(clk), .RESETN(resetn), .bus(b4.slave), .TX(tx4), .BUSY(busy4));
    uart_tx dut25 (.CLKIN(clk), .RESETN(resetn), .bus(b25.slave), .TX(tx25), .BUSY(busy25));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // line level t clocks after the accepting edge: start, 8 data LSB-first, [even parity], stop
    function automatic logic exp_tx(input logic [7:0] b, input int t, input int cpb);
        int k;
        if (t < 1 || t > NB * cpb) return 1'b1;
        k = (t - 1) / cpb;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NB == 11) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction
    function automatic logic [7:0] dec_step(input logic [7:0] d, input int t, input int cpb, input logic tx);
        logic [7:0] r = d;
        if (t >= 1 && (t - 1) % cpb == cpb / 2 && (t - 1) / cpb >= 1 && (t - 1) / cpb <= 8)
            r[(t - 1) / cpb - 1] = tx;
        return r;
    endfunction
    task automatic send(input int cpb, input logic [7:0] b, input bit scramble);
        int fl = NB * cpb;
        logic [7:0] dec = 8'h00;
        sel25 = (cpb != 4);
        dat = b;
        chk("ready_before_send", ready_o, 1'b1);
        if (sel25) v25 = 1'b1; else v4 = 1'b1;
        tick;
        v4 = 1'b0;
        v25 = 1'b0;
        for (int t = 0; t <= fl + 2; t++) begin
            if (t > 0) tick;
            if (scramble) dat = 8'($urandom);
            chk("tx", tx_o, exp_tx(b, t, cpb));
            chk("busy", busy_o, t >= 1 && t <= fl);
            chk("ready", ready_o, t >= fl);
            dec = dec_step(dec, t, cpb, tx_o);
        end
        chk("decoded", dec, b);
    endtask
    initial begin
        int fl, t2, stop_t, fall_t;
        logic prev;
        logic [7:0] d1, d2;
        // reset held with VALID high: nothing may start
        v4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_tx", tx4, 1'b1);
            chk("rst_busy", busy4, 1'b0);
            chk("rst_ready", b4.READY, 1'b0);
        end
        v4 = 1'b0;
        resetn = 1'b1;
        tick;
        chk("rel_ready", b4.READY, 1'b1);
        chk("rel_tx", tx4, 1'b1);
        chk("rel_busy", busy4, 1'b0);
        chk("rel_ready25", b25.READY, 1'b1);
        send(4, 8'h55, 1'b0);
        send(4, 8'h07, 1'b0);
        for (int i = 0; i < 4; i++) send(4, 8'($urandom), 1'b1);
        // back-to-back with VALID held; DATA scrambled during frame 1
        fl = NB * 4;
        stop_t = 1 + (NB - 1) * 4;
        fall_t = -1;
        d1 = 8'h00;
        d2 = 8'h00;
        sel25 = 1'b0;
        dat = 8'hA5;
        v4 = 1'b1;
        tick;
        prev = tx4;
        for (int t = 0; t <= 2 * fl + 3; t++) begin
            if (t > 0) tick;
            dat = (t < fl) ? 8'($urandom) : 8'h3C;
            if (t == fl + 1) v4 = 1'b0;
            t2 = t - (fl + 1);
            chk("b2b_tx", tx4, (t <= fl) ? exp_tx(8'hA5, t, 4) : exp_tx(8'h3C, t2, 4));
            chk("b2b_busy", busy4, (t >= 1 && t <= fl) || (t2 >= 1 && t2 <= fl));
            if (t > stop_t && prev && !tx4 && fall_t < 0) fall_t = t;
            prev = tx4;
            d1 = dec_step(d1, t, 4, tx4);
            d2 = dec_step(d2, t2, 4, tx4);
        end
        chk("b2b_gap", 32'(fall_t - stop_t), 32'd5);
        chk("b2b_byte1", d1, 8'hA5);
        chk("b2b_byte2", d2, 8'h3C);
        // single-cycle reset during data bit 3 of 0x00
        dat = 8'h00;
        v4 = 1'b1;
        tick;
        v4 = 1'b0;
        for (int t = 1; t <= 18; t++) tick;
        chk("pre_abort_tx", tx4, 1'b0);
        chk("pre_abort_busy", busy4, 1'b1);
        resetn = 1'b0;
        tick;
        chk("abort_tx", tx4, 1'b1);
        chk("abort_busy", busy4, 1'b0);
        chk("abort_ready", b4.READY, 1'b0);
        resetn = 1'b1;
        for (int t = 0; t < 2 * fl; t++) begin
            tick;
            chk("after_abort_tx", tx4, 1'b1);
            chk("after_abort_busy", busy4, 1'b0);
        end
        send(4, 8'hFF, 1'b0);
        send(25, 8'h80, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
